// File: rtl/axi_lite_rr_arb.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NoSlvPorts requesters.
// Read and write paths are arbitrated independently, each with one outstanding transaction.

package axi_lite_rr_arb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

endpackage

module axi_lite_rr_arb #(
  parameter int unsigned NoSlvPorts = 2,
  parameter type         req_t      = axi_lite_rr_arb_pkg::req_t,
  parameter type         resp_t     = axi_lite_rr_arb_pkg::resp_t,
  localparam int unsigned IdxW      = $clog2(NoSlvPorts)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  req_t            slv_reqs_i  [NoSlvPorts],
  output resp_t           slv_resps_o [NoSlvPorts],
  output req_t            mst_req_o,
  input  resp_t           mst_resp_i,
  output logic [IdxW-1:0] wr_idx_o,
  output logic [IdxW-1:0] rd_idx_o,
  output logic            wr_busy_o,
  output logic            rd_busy_o
);

  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP} rd_state_e;

  localparam logic [IdxW-1:0] LastInit = IdxW'(NoSlvPorts - 1);

  wr_state_e       r_wr_state;
  logic [IdxW-1:0] r_wr_idx;
  logic [IdxW-1:0] r_wr_last;
  logic            r_aw_done;
  logic            r_w_done;
  logic            r_wr_busy;

  rd_state_e       r_rd_state;
  logic [IdxW-1:0] r_rd_idx;
  logic [IdxW-1:0] r_rd_last;
  logic            r_rd_busy;

  logic [NoSlvPorts-1:0] w_aw_req;
  logic [NoSlvPorts-1:0] w_ar_req;
  logic [IdxW-1:0]       w_wr_pick;
  logic [IdxW-1:0]       w_rd_pick;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;

  // First requesting index strictly after 'last', wrapping modulo NoSlvPorts.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NoSlvPorts-1:0] req,
                                              input logic [IdxW-1:0]       last);
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] cand_idx;
    logic            found;
    int unsigned     cand;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NoSlvPorts; k++) begin
      cand     = (32'(last) + k) % NoSlvPorts;
      cand_idx = cand[IdxW-1:0];
      if (!found && req[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < NoSlvPorts; i++) begin
      w_aw_req[i] = slv_reqs_i[i].aw_valid;
      w_ar_req[i] = slv_reqs_i[i].ar_valid;
    end
    w_wr_pick = rr_pick(w_aw_req, r_wr_last);
    w_rd_pick = rr_pick(w_ar_req, r_rd_last);
  end

  assign w_aw_hs = (r_wr_state == WR_REQ) & slv_reqs_i[r_wr_idx].aw_valid & ~r_aw_done
                   & mst_resp_i.aw_ready;
  assign w_w_hs  = (r_wr_state == WR_REQ) & slv_reqs_i[r_wr_idx].w_valid & ~r_w_done
                   & mst_resp_i.w_ready;
  assign w_b_hs  = (r_wr_state == WR_RESP) & mst_resp_i.b_valid & slv_reqs_i[r_wr_idx].b_ready;
  assign w_ar_hs = (r_rd_state == RD_REQ) & slv_reqs_i[r_rd_idx].ar_valid & mst_resp_i.ar_ready;
  assign w_r_hs  = (r_rd_state == RD_RESP) & mst_resp_i.r_valid & slv_reqs_i[r_rd_idx].r_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= WR_IDLE;
      r_wr_idx   <= '0;
      r_wr_last  <= LastInit;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_wr_busy  <= 1'b0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (|w_aw_req) begin
            r_wr_idx   <= w_wr_pick;
            r_wr_last  <= w_wr_pick;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_busy  <= 1'b1;
            r_wr_state <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // AW and W may complete in either order or in the same cycle.
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) r_wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (w_b_hs) begin
            r_wr_state <= WR_IDLE;
            r_wr_busy  <= 1'b0;
          end
        end
        default: begin
          r_wr_state <= WR_IDLE;
          r_wr_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_rd_idx   <= '0;
      r_rd_last  <= LastInit;
      r_rd_busy  <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (|w_ar_req) begin
            r_rd_idx   <= w_rd_pick;
            r_rd_last  <= w_rd_pick;
            r_rd_busy  <= 1'b1;
            r_rd_state <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (w_ar_hs) r_rd_state <= RD_RESP;
        end
        RD_RESP: begin
          if (w_r_hs) begin
            r_rd_state <= RD_IDLE;
            r_rd_busy  <= 1'b0;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
          r_rd_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output is given a default before the muxing so no latch can be inferred.
  always_comb begin
    mst_req_o = '0;
    for (int i = 0; i < NoSlvPorts; i++) slv_resps_o[i] = '0;

    if (r_wr_state != WR_IDLE) begin
      mst_req_o.aw = slv_reqs_i[r_wr_idx].aw;
      mst_req_o.w  = slv_reqs_i[r_wr_idx].w;
    end
    if (r_wr_state == WR_REQ) begin
      mst_req_o.aw_valid = slv_reqs_i[r_wr_idx].aw_valid & ~r_aw_done;
      mst_req_o.w_valid  = slv_reqs_i[r_wr_idx].w_valid & ~r_w_done;
      slv_resps_o[r_wr_idx].aw_ready = mst_resp_i.aw_ready & ~r_aw_done;
      slv_resps_o[r_wr_idx].w_ready  = mst_resp_i.w_ready & ~r_w_done;
    end
    if (r_wr_state == WR_RESP) begin
      mst_req_o.b_ready             = slv_reqs_i[r_wr_idx].b_ready;
      slv_resps_o[r_wr_idx].b       = mst_resp_i.b;
      slv_resps_o[r_wr_idx].b_valid = mst_resp_i.b_valid;
    end

    if (r_rd_state != RD_IDLE) begin
      mst_req_o.ar = slv_reqs_i[r_rd_idx].ar;
    end
    if (r_rd_state == RD_REQ) begin
      mst_req_o.ar_valid             = slv_reqs_i[r_rd_idx].ar_valid;
      slv_resps_o[r_rd_idx].ar_ready = mst_resp_i.ar_ready;
    end
    if (r_rd_state == RD_RESP) begin
      mst_req_o.r_ready             = slv_reqs_i[r_rd_idx].r_ready;
      slv_resps_o[r_rd_idx].r       = mst_resp_i.r;
      slv_resps_o[r_rd_idx].r_valid = mst_resp_i.r_valid;
    end
  end

  assign wr_idx_o  = r_wr_idx;
  assign rd_idx_o  = r_rd_idx;
  assign wr_busy_o = r_wr_busy;
  assign rd_busy_o = r_rd_busy;

endmodule

// File: tb/tb_axi_lite_rr_arb.sv
// Directed testbench for axi_lite_rr_arb with four requesters and a hand-driven downstream slave.
module tb_axi_lite_rr_arb;
  import axi_lite_rr_arb_pkg::*;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst;
  req_t       slv_reqs  [N];
  resp_t      slv_resps [N];
  req_t       mst_req;
  resp_t      mst_resp;
  logic [1:0] wr_idx;
  logic [1:0] rd_idx;
  logic       wr_busy;
  logic       rd_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_rr_arb #(
    .NoSlvPorts(N),
    .req_t     (req_t),
    .resp_t    (resp_t)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_reqs_i (slv_reqs),
    .slv_resps_o(slv_resps),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .wr_idx_o   (wr_idx),
    .rd_idx_o   (rd_idx),
    .wr_busy_o  (wr_busy),
    .rd_busy_o  (rd_busy)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) slv_reqs[i] = '0;
    mst_resp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < N; i++) begin
      slv_reqs[i].aw_valid = 1'b1;
      slv_reqs[i].w_valid  = 1'b1;
      slv_reqs[i].ar_valid = 1'b1;
      slv_reqs[i].aw.addr  = 32'h40 + 32'(i);
      slv_reqs[i].ar.addr  = 32'h80 + 32'(i);
    end
    rst = 1'b1;
    repeat (3) step();
    #1;
    n_checks++;
    if (mst_req !== '0) $display("FAIL reset_mst_req: got %h want 0", mst_req); else n_pass++;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (slv_resps[i] !== '0) $display("FAIL reset_slv_resp%0d: got %h want 0", i, slv_resps[i]);
      else n_pass++;
    end
    n_checks++;
    if ({wr_idx, rd_idx} !== 4'd0) $display("FAIL reset_idx: got %b want 0000", {wr_idx, rd_idx});
    else n_pass++;
    n_checks++;
    if ({wr_busy, rd_busy} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {wr_busy, rd_busy});
    else n_pass++;
    rst = 1'b0;
    step();
    #1;
    n_checks++;
    if (wr_idx !== 2'd0) $display("FAIL first_wr_grant: got %0d want 0", wr_idx); else n_pass++;
    n_checks++;
    if (rd_idx !== 2'd0) $display("FAIL first_rd_grant: got %0d want 0", rd_idx); else n_pass++;
    n_checks++;
    if ({mst_req.aw_valid, mst_req.ar_valid} !== 2'b11)
      $display("FAIL first_valids: got %b want 11", {mst_req.aw_valid, mst_req.ar_valid});
    else n_pass++;
    n_checks++;
    if (mst_req.aw.addr !== 32'h40) $display("FAIL first_aw_addr: got %h want 00000040", mst_req.aw.addr);
    else n_pass++;
    n_checks++;
    if (mst_req.ar.addr !== 32'h80) $display("FAIL first_ar_addr: got %h want 00000080", mst_req.ar.addr);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit         got;
    int         p;
    logic [1:0] exp_resp;
    logic [3:0] bv;
    do_reset();
    for (int i = 0; i < N; i++) begin
      slv_reqs[i].aw_valid = 1'b1;
      slv_reqs[i].w_valid  = 1'b1;
      slv_reqs[i].b_ready  = 1'b1;
      slv_reqs[i].aw.addr  = 32'h100 + 32'(4 * i);
      slv_reqs[i].w.data   = 32'hA000_0000 + 32'(i);
      slv_reqs[i].w.strb   = 4'hF;
    end
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.b_valid  = 1'b1;
    for (int t = 0; t < 5; t++) begin
      p   = t % N;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        step();
        if (mst_req.aw_valid === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got) $display("FAIL rr_grant_timeout: got no aw_valid want grant %0d", p); else n_pass++;
      n_checks++;
      if (wr_idx !== 2'(p)) $display("FAIL rr_order_%0d: got %0d want %0d", t, wr_idx, p); else n_pass++;
      n_checks++;
      if (mst_req.aw.addr !== 32'h100 + 32'(4 * p))
        $display("FAIL rr_addr_%0d: got %h want %h", t, mst_req.aw.addr, 32'h100 + 32'(4 * p));
      else n_pass++;
      exp_resp = 2'(t) ^ 2'b10;
      mst_resp.b.resp = exp_resp;
      step();
      #1;
      for (int i = 0; i < N; i++) bv[i] = slv_resps[i].b_valid;
      n_checks++;
      if (bv !== 4'(1 << p)) $display("FAIL rr_b_route_%0d: got %b want %b", t, bv, 4'(1 << p));
      else n_pass++;
      n_checks++;
      if (slv_resps[p].b.resp !== exp_resp)
        $display("FAIL rr_bresp_%0d: got %b want %b", t, slv_resps[p].b.resp, exp_resp);
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_aw_w_independence();
    do_reset();
    slv_reqs[2].w_valid = 1'b1;
    slv_reqs[2].w.data  = 32'h5555_AAAA;
    slv_reqs[2].b_ready = 1'b1;
    step();
    #1;
    n_checks++;
    if ({wr_busy, mst_req.w_valid} !== 2'b00)
      $display("FAIL wonly_no_grant: got %b want 00", {wr_busy, mst_req.w_valid});
    else n_pass++;
    step();
    slv_reqs[2].aw_valid = 1'b1;
    slv_reqs[2].aw.addr  = 32'h200;
    mst_resp.w_ready     = 1'b1;
    mst_resp.aw_ready    = 1'b0;
    step();
    #1;
    n_checks++;
    if (wr_idx !== 2'd2) $display("FAIL awd_grant: got %0d want 2", wr_idx); else n_pass++;
    n_checks++;
    if ({mst_req.aw_valid, mst_req.w_valid} !== 2'b11)
      $display("FAIL awd_both_valid: got %b want 11", {mst_req.aw_valid, mst_req.w_valid});
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({mst_req.aw_valid, mst_req.w_valid} !== 2'b10)
      $display("FAIL awd_w_done_only: got %b want 10", {mst_req.aw_valid, mst_req.w_valid});
    else n_pass++;
    mst_resp.aw_ready = 1'b1;
    #1;
    n_checks++;
    if ({slv_resps[2].aw_ready, slv_resps[2].w_ready} !== 2'b10)
      $display("FAIL awd_readies: got %b want 10", {slv_resps[2].aw_ready, slv_resps[2].w_ready});
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({mst_req.b_ready, mst_req.aw_valid} !== 2'b10)
      $display("FAIL awd_resp_entered: got %b want 10", {mst_req.b_ready, mst_req.aw_valid});
    else n_pass++;
    slv_reqs[2].aw_valid = 1'b0;
    slv_reqs[2].w_valid  = 1'b0;
    mst_resp.b_valid     = 1'b1;
    step();
    #1;
    n_checks++;
    if (wr_busy !== 1'b0) $display("FAIL awd_idle: got %b want 0", wr_busy); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_concurrent();
    do_reset();
    slv_reqs[0].aw_valid = 1'b1;
    slv_reqs[0].aw.addr  = 32'h10;
    slv_reqs[0].w_valid  = 1'b1;
    slv_reqs[0].w.data   = 32'hDEAD_BEEF;
    slv_reqs[0].w.strb   = 4'hF;
    slv_reqs[0].b_ready  = 1'b1;
    slv_reqs[1].ar_valid = 1'b1;
    slv_reqs[1].ar.addr  = 32'h20;
    slv_reqs[1].r_ready  = 1'b1;
    mst_resp.aw_ready    = 1'b1;
    mst_resp.w_ready     = 1'b1;
    mst_resp.ar_ready    = 1'b1;
    step();
    #1;
    n_checks++;
    if ({wr_idx, rd_idx} !== {2'd0, 2'd1}) $display("FAIL cc_idx: got %b want 0001", {wr_idx, rd_idx});
    else n_pass++;
    n_checks++;
    if ({mst_req.aw.addr, mst_req.w.data, mst_req.ar.addr} !== {32'h10, 32'hDEAD_BEEF, 32'h20})
      $display("FAIL cc_payload: got %h %h %h want 00000010 deadbeef 00000020",
               mst_req.aw.addr, mst_req.w.data, mst_req.ar.addr);
    else n_pass++;
    n_checks++;
    if ({wr_busy, rd_busy} !== 2'b11) $display("FAIL cc_busy_overlap: got %b want 11", {wr_busy, rd_busy});
    else n_pass++;
    step();
    slv_reqs[0].aw_valid = 1'b0;
    slv_reqs[0].w_valid  = 1'b0;
    slv_reqs[1].ar_valid = 1'b0;
    mst_resp.r.data      = 32'h1234_5678;
    mst_resp.r_valid     = 1'b1;
    mst_resp.b_valid     = 1'b1;
    mst_resp.b.resp      = 2'b00;
    #1;
    n_checks++;
    if ({slv_resps[1].r_valid, slv_resps[1].r.data} !== {1'b1, 32'h1234_5678})
      $display("FAIL cc_rdata_p1: got %b %h want 1 12345678", slv_resps[1].r_valid, slv_resps[1].r.data);
    else n_pass++;
    n_checks++;
    if ({slv_resps[0].r_valid, slv_resps[0].r.data} !== 33'd0)
      $display("FAIL cc_rdata_p0: got %b %h want 0 00000000", slv_resps[0].r_valid, slv_resps[0].r.data);
    else n_pass++;
    n_checks++;
    if ({slv_resps[0].b_valid, slv_resps[1].b_valid} !== 2'b10)
      $display("FAIL cc_b_route: got %b want 10", {slv_resps[0].b_valid, slv_resps[1].b_valid});
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({wr_busy, rd_busy} !== 2'b00) $display("FAIL cc_done: got %b want 00", {wr_busy, rd_busy});
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      slv_reqs[i].aw_valid = 1'b1;
      slv_reqs[i].w_valid  = 1'b1;
      slv_reqs[i].b_ready  = (i != 0);
    end
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.b_valid  = 1'b1;
    step();
    #1;
    n_checks++;
    if (wr_idx !== 2'd0) $display("FAIL bp_grant: got %0d want 0", wr_idx); else n_pass++;
    step();
    slv_reqs[0].aw_valid = 1'b0;
    slv_reqs[0].w_valid  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (mst_req.b_ready !== 1'b0) $display("FAIL bp_b_ready_%0d: got %b want 0", k, mst_req.b_ready);
      else n_pass++;
      n_checks++;
      if ({wr_busy, wr_idx, mst_req.aw_valid} !== 4'b1000)
        $display("FAIL bp_hold_%0d: got %b want 1000", k, {wr_busy, wr_idx, mst_req.aw_valid});
      else n_pass++;
      step();
    end
    slv_reqs[0].b_ready = 1'b1;
    #1;
    n_checks++;
    if ({mst_req.b_ready, slv_resps[0].b_valid} !== 2'b11)
      $display("FAIL bp_release: got %b want 11", {mst_req.b_ready, slv_resps[0].b_valid});
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (wr_busy !== 1'b0) $display("FAIL bp_idle_first: got %b want 0", wr_busy); else n_pass++;
    step();
    #1;
    n_checks++;
    if ({wr_busy, wr_idx} !== 3'b101) $display("FAIL bp_next_grant: got %b want 101", {wr_busy, wr_idx});
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    bit got;
    int c0;
    do_reset();
    slv_reqs[3].aw_valid = 1'b1;
    slv_reqs[3].w_valid  = 1'b1;
    slv_reqs[3].b_ready  = 1'b1;
    mst_resp.aw_ready    = 1'b1;
    mst_resp.w_ready     = 1'b1;
    mst_resp.b_valid     = 1'b1;
    c0 = 0;
    for (int t = 0; t < 3; t++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        step();
        if (mst_req.aw_valid === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got || wr_idx !== 2'd3) $display("FAIL b2b_regrant_%0d: got %b/%0d want 1/3", t, got, wr_idx);
      else n_pass++;
      if (t > 0) begin
        n_checks++;
        if (cyc - c0 != 3) $display("FAIL b2b_period_%0d: got %0d want 3", t, cyc - c0); else n_pass++;
      end
      c0 = cyc;
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    slv_reqs[0].aw_valid = 1'b1;
    slv_reqs[0].w_valid  = 1'b1;
    slv_reqs[0].aw.addr  = 32'h30;
    mst_resp.aw_ready    = 1'b1;
    mst_resp.w_ready     = 1'b0;
    step();
    step();
    #1;
    n_checks++;
    if ({mst_req.aw_valid, mst_req.w_valid} !== 2'b01)
      $display("FAIL mr_aw_done: got %b want 01", {mst_req.aw_valid, mst_req.w_valid});
    else n_pass++;
    rst = 1'b1;
    step();
    #1;
    n_checks++;
    if (mst_req !== '0) $display("FAIL mr_mst_req: got %h want 0", mst_req); else n_pass++;
    n_checks++;
    if ({wr_busy, wr_idx} !== 3'b000) $display("FAIL mr_state: got %b want 000", {wr_busy, wr_idx});
    else n_pass++;
    n_checks++;
    if (slv_resps[0] !== '0) $display("FAIL mr_slv_resp0: got %h want 0", slv_resps[0]); else n_pass++;
    rst                  = 1'b0;
    slv_reqs[0]          = '0;
    slv_reqs[1].aw_valid = 1'b1;
    slv_reqs[1].w_valid  = 1'b1;
    slv_reqs[1].aw.addr  = 32'h34;
    mst_resp.w_ready     = 1'b1;
    step();
    #1;
    n_checks++;
    if ({wr_idx, mst_req.aw_valid} !== 3'b011) $display("FAIL mr_regrant: got %b want 011", {wr_idx, mst_req.aw_valid});
    else n_pass++;
    n_checks++;
    if (mst_req.aw.addr !== 32'h34) $display("FAIL mr_addr: got %h want 00000034", mst_req.aw.addr);
    else n_pass++;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_aw_w_independence();
    test_concurrent();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
